// File: rtl/bcd_stopwatch_if.sv
// Stopwatch control/status bundle; the lap signals exist only when LAP_HOLD_EN is defined.
interface bcd_stopwatch_if #(
  parameter int unsigned DIGITS = 2
);
  logic                  start_stop;
  logic                  clear;
  logic                  dir;
  logic                  running;
  logic [4*DIGITS-1:0]   bcd;
  logic [9*DIGITS-1:0]   seg_led;
  logic                  wrap_pulse;
`ifdef LAP_HOLD_EN
  logic                  lap;
  logic                  lap_active;

  modport master (output start_stop, clear, dir, lap,
                  input  running, bcd, seg_led, wrap_pulse, lap_active);
  modport slave  (input  start_stop, clear, dir, lap,
                  output running, bcd, seg_led, wrap_pulse, lap_active);
`else
  modport master (output start_stop, clear, dir,
                  input  running, bcd, seg_led, wrap_pulse);
  modport slave  (input  start_stop, clear, dir,
                  output running, bcd, seg_led, wrap_pulse);
`endif
endinterface

// File: rtl/bcd_stopwatch_counter.sv
// Start/stop BCD stopwatch with prescaler, up/down wrap counting and registered 7-seg encoding.
// Optional lap freeze of the displays is enabled with the LAP_HOLD_EN macro.
module bcd_stopwatch_counter #(
  parameter int unsigned CLK_DIV = 3464,
  parameter int unsigned DIGITS  = 2,
  parameter int unsigned WRAP    = 20
) (
  input logic            clk,
  input logic            rst,
  bcd_stopwatch_if.slave sw
);
  localparam int unsigned PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned SW = 9 * DIGITS;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [SW-1:0] SEG_ZERO = {DIGITS{9'h03f}};

  // Elaboration-time conversion of the terminal count to packed BCD.
  function automatic logic [BW-1:0] to_bcd(input int unsigned v);
    logic [BW-1:0] res;
    int unsigned   x;
    res = '0;
    x   = v;
    for (int i = 0; i < int'(DIGITS); i++) begin
      res[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return res;
  endfunction

  localparam logic [BW-1:0] WRAP_MAX = to_bcd(WRAP - 1);

  function automatic logic [8:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 9'h03f;
      4'd1:    seg_code = 9'h006;
      4'd2:    seg_code = 9'h05b;
      4'd3:    seg_code = 9'h04f;
      4'd4:    seg_code = 9'h066;
      4'd5:    seg_code = 9'h06d;
      4'd6:    seg_code = 9'h07d;
      4'd7:    seg_code = 9'h007;
      4'd8:    seg_code = 9'h07f;
      4'd9:    seg_code = 9'h06f;
      default: seg_code = 9'h000;
    endcase
  endfunction

  logic [PW-1:0] r_presc;
  logic [BW-1:0] r_bcd;
  logic [SW-1:0] r_seg;
  logic          r_running;
  logic          r_wrap;

  logic [BW-1:0] w_inc;
  logic [BW-1:0] w_dec;
  logic [BW-1:0] w_next_bcd;
  logic [SW-1:0] w_seg;
  logic          w_tick;
  logic          w_wrap;
  logic          w_seg_hold;

  assign w_tick = r_running && (r_presc == PRE_LAST) && !sw.clear;

  // Ripple BCD increment and decrement, digit by digit.
  always_comb begin
    logic carry;
    logic borrow;
    carry  = 1'b1;
    borrow = 1'b1;
    w_inc  = r_bcd;
    w_dec  = r_bcd;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (carry) begin
        if (r_bcd[4*i +: 4] == 4'd9) begin
          w_inc[4*i +: 4] = 4'd0;
        end else begin
          w_inc[4*i +: 4] = r_bcd[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (r_bcd[4*i +: 4] == 4'd0) begin
          w_dec[4*i +: 4] = 4'd9;
        end else begin
          w_dec[4*i +: 4] = r_bcd[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_next_bcd = w_inc;
    w_wrap     = 1'b0;
    if (sw.dir) begin
      w_wrap     = (r_bcd == '0);
      w_next_bcd = w_wrap ? WRAP_MAX : w_dec;
    end else begin
      w_wrap     = (r_bcd == WRAP_MAX);
      w_next_bcd = w_wrap ? '0 : w_inc;
    end
  end

  always_comb begin
    w_seg = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      w_seg[9*i +: 9] = seg_code(r_bcd[4*i +: 4]);
    end
  end

  // Run flag, prescaler and count; clear outranks the tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_running <= 1'b0;
      r_presc   <= '0;
      r_bcd     <= '0;
      r_wrap    <= 1'b0;
    end else begin
      if (sw.start_stop) r_running <= !r_running;
      r_wrap <= 1'b0;
      if (sw.clear) begin
        r_presc <= '0;
        r_bcd   <= '0;
      end else if (r_running) begin
        r_presc <= (r_presc == PRE_LAST) ? '0 : r_presc + PW'(1);
        if (w_tick) begin
          r_bcd  <= w_next_bcd;
          r_wrap <= w_wrap;
        end
      end
    end
  end

`ifdef LAP_HOLD_EN
  logic r_lap_active;

  always_ff @(posedge clk) begin
    if (rst || sw.clear) r_lap_active <= 1'b0;
    else if (sw.lap)     r_lap_active <= !r_lap_active;
  end

  assign w_seg_hold    = r_lap_active;
  assign sw.lap_active = r_lap_active;
`else
  assign w_seg_hold = 1'b0;
`endif

  // Display register trails the count by one clock unless frozen.
  always_ff @(posedge clk) begin
    if (rst)              r_seg <= SEG_ZERO;
    else if (!w_seg_hold) r_seg <= w_seg;
  end

  assign sw.running    = r_running;
  assign sw.bcd        = r_bcd;
  assign sw.seg_led    = r_seg;
  assign sw.wrap_pulse = r_wrap;
endmodule

// File: tb/tb_bcd_stopwatch_counter.sv
// Directed bench for bcd_stopwatch_counter (CLK_DIV=4, DIGITS=2, WRAP=20) with a BCD scoreboard.
module tb_bcd_stopwatch_counter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_stopwatch_if #(.DIGITS(2)) sw();

  bcd_stopwatch_counter #(.CLK_DIV(4), .DIGITS(2), .WRAP(20)) dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw)
  );

  int         checks = 0;
  int         errors = 0;
  int         m_cnt  = 0;
  logic [7:0] exp_q[$];

  function automatic logic [7:0] bcd_of(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_chk(input string tag);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=0x%0h expected=<empty scoreboard>", tag, sw.bcd);
    end else begin
      chk(tag, 32'(sw.bcd), 32'(exp_q.pop_front()));
    end
  endtask

  // Advance the integer model by one count step, then wait n clocks for the DUT tick.
  task automatic tick_step(input string tag, input int n);
    if (sw.dir) m_cnt = (m_cnt == 0) ? 19 : m_cnt - 1;
    else        m_cnt = (m_cnt == 19) ? 0 : m_cnt + 1;
    exp_q.push_back(bcd_of(m_cnt));
    cyc(n);
    pop_chk(tag);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_run"},  32'(sw.running),    32'd0);
    chk({tag, "_bcd"},  32'(sw.bcd),        32'h00);
    chk({tag, "_seg"},  32'(sw.seg_led),    32'h7e3f);
    chk({tag, "_wrap"}, 32'(sw.wrap_pulse), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    sw.start_stop = 1'b0;
    sw.clear = 1'b0;
    sw.dir = 1'b0;
`ifdef LAP_HOLD_EN
    sw.lap = 1'b0;
`endif
    cyc(2);
    rst = 1'b0;
    chk_reset("rst");
`ifdef LAP_HOLD_EN
    chk("rst_lap", 32'(sw.lap_active), 32'd0);
`endif

    // Start and count up from zero.
    sw.start_stop = 1'b1;
    cyc(1);
    sw.start_stop = 1'b0;
    chk("run_on", 32'(sw.running), 32'd1);
    exp_q.push_back(bcd_of(0));
    cyc(3);
    pop_chk("t1_hold");
    tick_step("t1_one", 1);
    cyc(1);
    chk("t1_seg", 32'(sw.seg_led[8:0]), 32'h006);
    tick_step("t1_two", 3);

    for (int i = 0; i < 16; i++) tick_step("up_run", 4);
    tick_step("up_19", 4);
    chk("wrap_lo", 32'(sw.wrap_pulse), 32'd0);
    tick_step("up_wrap", 4);
    chk("wrap_hi", 32'(sw.wrap_pulse), 32'd1);
    cyc(1);
    chk("wrap_one", 32'(sw.wrap_pulse), 32'd0);
    chk("wrap_seg", 32'(sw.seg_led), 32'h7e3f);

    // Count down: underflow wrap, then borrow across digits.
    sw.dir = 1'b1;
    tick_step("dn_wrap", 3);
    chk("dn_wrap_p", 32'(sw.wrap_pulse), 32'd1);
    for (int i = 0; i < 9; i++) tick_step("dn_run", 4);
    tick_step("dn_borrow", 4);
    sw.dir = 1'b0;

    // Stop on a tick cycle: tick still applies, then count holds.
    cyc(3);
    sw.start_stop = 1'b1;
    m_cnt = 10;
    exp_q.push_back(bcd_of(m_cnt));
    cyc(1);
    sw.start_stop = 1'b0;
    pop_chk("stop_tick");
    chk("stop_run", 32'(sw.running), 32'd0);
    exp_q.push_back(bcd_of(m_cnt));
    cyc(20);
    pop_chk("stop_held");
    sw.start_stop = 1'b1;
    cyc(1);
    sw.start_stop = 1'b0;
    tick_step("resume", 4);

    // Stop mid-period; resume finishes the remaining period only.
    cyc(1);
    sw.start_stop = 1'b1;
    cyc(1);
    sw.start_stop = 1'b0;
    chk("mid_stop", 32'(sw.running), 32'd0);
    exp_q.push_back(bcd_of(m_cnt));
    cyc(20);
    pop_chk("mid_held");
    sw.start_stop = 1'b1;
    cyc(1);
    sw.start_stop = 1'b0;
    exp_q.push_back(bcd_of(m_cnt));
    cyc(1);
    pop_chk("mid_wait");
    tick_step("mid_tick", 1);

    // Clear on a tick cycle, then clear on a would-be underflow wrap.
    cyc(3);
    sw.clear = 1'b1;
    m_cnt = 0;
    exp_q.push_back(bcd_of(m_cnt));
    cyc(1);
    sw.clear = 1'b0;
    pop_chk("clr_tick");
    chk("clr_wrap", 32'(sw.wrap_pulse), 32'd0);
    chk("clr_run", 32'(sw.running), 32'd1);
    sw.dir = 1'b1;
    cyc(3);
    sw.clear = 1'b1;
    exp_q.push_back(bcd_of(m_cnt));
    cyc(1);
    sw.clear = 1'b0;
    pop_chk("clr_dn");
    chk("clr_dn_wrap", 32'(sw.wrap_pulse), 32'd0);
    sw.dir = 1'b0;
    tick_step("clr_presc", 4);

    // Reset mid-count.
    cyc(2);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk_reset("rst_mid");
    m_cnt = 0;

`ifdef LAP_HOLD_EN
    // Lap freeze and release.
    sw.start_stop = 1'b1;
    cyc(1);
    sw.start_stop = 1'b0;
    for (int i = 0; i < 7; i++) tick_step("lap_run", 4);
    sw.lap = 1'b1;
    cyc(1);
    sw.lap = 1'b0;
    chk("lap_on", 32'(sw.lap_active), 32'd1);
    chk("lap_seg7", 32'(sw.seg_led), 32'h7e07);
    tick_step("lap_cnt8", 4);
    tick_step("lap_cnt9", 4);
    chk("lap_frozen", 32'(sw.seg_led), 32'h7e07);
    sw.lap = 1'b1;
    cyc(1);
    sw.lap = 1'b0;
    chk("lap_off", 32'(sw.lap_active), 32'd0);
    chk("lap_lag", 32'(sw.seg_led), 32'h7e07);
    cyc(1);
    chk("lap_seg9", 32'(sw.seg_led), 32'h7e6f);
    sw.lap = 1'b1;
    cyc(1);
    sw.lap = 1'b0;
    chk("lap_on2", 32'(sw.lap_active), 32'd1);
    sw.clear = 1'b1;
    cyc(1);
    sw.clear = 1'b0;
    chk("lap_clr", 32'(sw.lap_active), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_stopwatch_counter.md
Name: bcd_stopwatch_counter

Overview:
Parametrised start/stop decimal stopwatch that drives DIGITS seven-segment displays.
- Divides clk down to a count tick and counts in packed BCD (no divide/modulo), modulo WRAP, up or down.
- Encodes each digit to a 9-bit segment code.
- Sits behind the key debouncer: consumes its single-cycle pulses and feeds the segment pins directly.

Parameters:
CLK_DIV, 3464, clk cycles per count step (>=2)
DIGITS, 2, number of BCD digits / displays (1..6)
WRAP, 20, count range 0..WRAP-1 (2..10^DIGITS)

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
start_stop  input  1  debounced single-cycle pulse; toggles running
clear  input  1  level; zeroes count and prescaler
dir  input  1  0 = count up, 1 = count down; sampled on each tick
running  output  1  1 while counting is enabled
bcd  output  4*DIGITS  packed BCD count; digit 0 (units) in [3:0]
seg_led  output  9*DIGITS  segment codes; digit k in [9k+8:9k]
wrap_pulse  output  1  one-cycle pulse when count wraps in either direction

Behaviour:
Reset (rst=1 at clk edge): prescaler=0, bcd=0, running=0, wrap_pulse=0, seg_led = code "0" on every digit.

Prescaler:
- Counts 0..CLK_DIV-1 only while running=1; holds its value while stopped, so resume continues mid-period.
- tick is asserted for the cycle in which prescaler==CLK_DIV-1 and running=1; prescaler returns to 0 on that edge.

Running:
- start_stop=1 toggles running on the next edge.
- A tick in the same cycle uses the pre-toggle running value: the tick is still applied when stopping.

Count update on tick:
- dir=0: BCD increment with per-digit carry (9 -> 0, carry to the next digit). If count==WRAP-1, count becomes 0 and wrap_pulse=1 next cycle.
- dir=1: BCD decrement with per-digit borrow (0 -> 9). If count==0, count becomes WRAP-1 and wrap_pulse=1 next cycle.
- Count is held as packed BCD. WRAP-1 is converted to a BCD constant at elaboration.

Clear:
- clear=1 forces bcd=0 and prescaler=0 on the next edge and suppresses tick and wrap_pulse that cycle.
- running is unaffected, except that a simultaneous start_stop still toggles it.

Priority: rst > clear > tick.

Segment encoding:
- Registered; seg_led lags bcd by exactly 1 clk.
- Bits [6:0] = g..a, active-high; bits [8:7] = 0.
- Codes: 0=0x3f, 1=0x06, 2=0x5b, 3=0x4f, 4=0x66, 5=0x6d, 6=0x7d, 7=0x07, 8=0x7f, 9=0x6f.
- Non-BCD nibbles are unreachable; the encoder outputs 0x00 for them.

Outputs:
- bcd and running are registered.
- wrap_pulse is high for exactly one cycle per wrap.

Optional Feature:
Macro LAP_HOLD_EN.
- Defined: adds input lap (1-bit debounced pulse).
  - First lap pulse freezes seg_led at the current value; counting, bcd and wrap_pulse continue.
  - Second lap pulse releases the freeze: seg_led tracks bcd again, still with 1-cycle lag.
  - Extra output lap_active (1 while frozen), reset 0.
  - clear or rst also release the freeze.
- Undefined: no lap port and no lap_active port; seg_led always tracks bcd.

Test Plan:
All scenarios use CLK_DIV=4, DIGITS=2, WRAP=20.
1. Reset, then one start_stop pulse, dir=0 -> bcd=0x01 after 4 clks, 0x02 after 8; seg_led[8:0]=0x06 one clk after bcd=0x01.
2. Run up from 0x18 -> 0x19 then 0x00; wrap_pulse high exactly 1 cycle; seg_led[17:9]=0x3f, seg_led[8:0]=0x3f.
3. dir=1 from 0x00 -> next tick gives 0x19, wrap_pulse=1. Then from 0x10 -> 0x09 (borrow across digits).
4. start_stop pulse coinciding with a tick cycle -> that tick still increments; afterwards running=0 and bcd holds for >=20 clks. Second pulse resumes with no prescaler reset: first new tick arrives after the remaining period.
5. clear asserted on a tick cycle -> bcd=0x00 next edge, no increment, wrap_pulse=0; rst mid-count -> all outputs at reset values next edge.
6. (LAP_HOLD_EN) lap pulse at bcd=0x07 -> seg_led stays 0x07 code while bcd reaches 0x09. Second lap -> seg_led shows 0x6f one clk later; lap_active toggles 1 then 0.
